// File: rtl/microsequencer_if.sv
// Control-register/status bundle between the control unit and the microsequencer.
// The control side drives master; the sequencer uses slave.
interface microsequencer_if;
  logic [2:0] N;
  logic       inv;
  logic [9:0] cr;
  logic [9:0] decoded_state;
  logic       cond;
  logic       moc;
  logic [9:0] current_state;
  logic       moc_wait;
  logic       stack_err;
  logic       timeout;

  modport master (
    output N, inv, cr, decoded_state, cond, moc,
    input  current_state, moc_wait, stack_err, timeout
  );

  modport slave (
    input  N, inv, cr, decoded_state, cond, moc,
    output current_state, moc_wait, stack_err, timeout
  );
endinterface

// File: rtl/microsequencer.sv
// Next-address logic for the microprogrammed control unit with a LIFO return stack.
// Optional MOC-wait watchdog enabled by defining MICROSEQ_MOC_TIMEOUT_EN.
module microsequencer #(
  parameter logic [9:0]  FETCH_STATE = 10'd1,
  parameter logic [9:0]  RESET_STATE = 10'd0,
  parameter logic [9:0]  FAULT_STATE = 10'd1023,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned MOC_TIMEOUT = 255
) (
  input logic           clk,
  input logic           reset_n,
  microsequencer_if.slave bus
);

  localparam int unsigned PW = $clog2(STACK_DEPTH) + 1;
  localparam int unsigned IW = PW - 1;
  localparam logic [PW-1:0] SP_FULL = PW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    N_DECODE = 3'd0,
    N_FETCH  = 3'd1,
    N_JUMP   = 3'd2,
    N_INCR   = 3'd3,
    N_BRANCH = 3'd4,
    N_MOC    = 3'd5,
    N_CALL   = 3'd6,
    N_RET    = 3'd7
  } n_op_e;

  n_op_e         op;
  logic [9:0]    state_q, state_d;
  logic          moc_wait_q, moc_wait_d;
  logic          stack_err_q, stack_err_d;
  logic [PW-1:0] sp_q, sp_d;
  logic [9:0]    stack_q [STACK_DEPTH];
  logic [9:0]    stack_d [STACK_DEPTH];
  logic [PW-1:0] sp_dec;
  logic [9:0]    incr;
  logic          t, m;
  logic          hold_req;

  assign op     = n_op_e'(bus.N);
  assign incr   = state_q + 10'd1;
  assign t      = bus.cond ^ bus.inv;
  assign m      = bus.moc ^ bus.inv;
  assign sp_dec = sp_q - PW'(1);

`ifdef MICROSEQ_MOC_TIMEOUT_EN
  localparam logic [8:0] TMO_LIMIT = 9'(MOC_TIMEOUT);
  logic [8:0] tmo_cnt_q, tmo_cnt_d;
  logic       timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = incr;
    moc_wait_d  = 1'b0;
    stack_err_d = stack_err_q;
    sp_d        = sp_q;
    stack_d     = stack_q;
    hold_req    = 1'b0;
    unique case (op)
      N_DECODE: state_d = bus.decoded_state;
      N_FETCH:  state_d = FETCH_STATE;
      N_JUMP:   state_d = bus.cr;
      N_INCR:   state_d = incr;
      N_BRANCH: state_d = t ? bus.cr : incr;
      N_MOC: begin
        if (!m) begin
          hold_req   = 1'b1;
          state_d    = state_q;
          moc_wait_d = 1'b1;
        end
      end
      N_CALL: begin
        if (sp_q == SP_FULL) begin
          state_d     = FAULT_STATE;
          stack_err_d = 1'b1;
        end else begin
          stack_d[sp_q[IW-1:0]] = incr;
          sp_d    = sp_q + PW'(1);
          state_d = bus.cr;
        end
      end
      N_RET: begin
        if (sp_q == '0) begin
          state_d     = FAULT_STATE;
          stack_err_d = 1'b1;
        end else begin
          state_d = stack_q[sp_dec[IW-1:0]];
          sp_d    = sp_dec;
        end
      end
      default: state_d = incr;
    endcase

`ifdef MICROSEQ_MOC_TIMEOUT_EN
    // Watchdog overrides a hold once the limit has been reached; any non-hold update clears the count.
    tmo_cnt_d = '0;
    timeout_d = timeout_q;
    if (hold_req) begin
      if (tmo_cnt_q == TMO_LIMIT) begin
        state_d    = FAULT_STATE;
        moc_wait_d = 1'b0;
        timeout_d  = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 9'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      moc_wait_q  <= 1'b0;
      stack_err_q <= 1'b0;
      sp_q        <= '0;
    end else begin
      state_q     <= state_d;
      moc_wait_q  <= moc_wait_d;
      stack_err_q <= stack_err_d;
      sp_q        <= sp_d;
    end
  end

  // Stack contents need no reset: an empty pointer makes them unreachable.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

`ifdef MICROSEQ_MOC_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  // Without the watchdog the hold request and limit have no consumer.
  logic unused_tmo;
  assign unused_tmo  = hold_req ^ (|9'(MOC_TIMEOUT));
  assign bus.timeout = 1'b0;
`endif

  assign bus.current_state = state_q;
  assign bus.moc_wait      = moc_wait_q;
  assign bus.stack_err     = stack_err_q;

endmodule

// File: tb/tb_microsequencer.sv
// Randomized and directed checks of microsequencer against a queue-based reference model.
module tb_microsequencer;
  localparam int TMO = 4;
`ifdef MICROSEQ_MOC_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk;
  logic reset_n;
  microsequencer_if bus ();

  microsequencer #(
    .FETCH_STATE (10'd1),
    .RESET_STATE (10'd0),
    .FAULT_STATE (10'd1023),
    .STACK_DEPTH (4),
    .MOC_TIMEOUT (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_state;
  int stk[$];
  bit m_wait, m_err, m_tmo;
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    stk.delete();
    m_wait = 0;
    m_err  = 0;
    m_tmo  = 0;
    m_cnt  = 0;
  endtask

  task automatic model_step(input int n, input int c, input bit iv, input bit cd,
                            input bit mc, input int dec);
    int  inc  = (m_state + 1) % 1024;
    bit  t    = cd ^ iv;
    bit  mm   = mc ^ iv;
    bit  hold = 0;
    m_wait = 0;
    case (n)
      0: m_state = dec;
      1: m_state = 1;
      2: m_state = c;
      3: m_state = inc;
      4: m_state = t ? c : inc;
      5: begin
        if (mm) m_state = inc;
        else if (TMO_EN && m_cnt == TMO) begin
          m_state = 1023;
          m_tmo   = 1;
        end else begin
          hold   = 1;
          m_wait = 1;
          m_cnt++;
        end
      end
      6: begin
        if (stk.size() == 4) begin
          m_state = 1023;
          m_err   = 1;
        end else begin
          stk.push_back(inc);
          m_state = c;
        end
      end
      default: begin
        if (stk.size() == 0) begin
          m_state = 1023;
          m_err   = 1;
        end else m_state = stk.pop_back();
      end
    endcase
    if (!hold) m_cnt = 0;
  endtask

  task automatic step(input logic [2:0] n, input logic [9:0] c = '0, input logic iv = 0,
                      input logic cd = 0, input logic mc = 0, input logic [9:0] dec = '0);
    bus.N = n;
    bus.cr = c;
    bus.inv = iv;
    bus.cond = cd;
    bus.moc = mc;
    bus.decoded_state = dec;
    @(posedge clk);
    model_step(int'(n), int'(c), iv, cd, mc, int'(dec));
    #1;
    check("state", 32'(bus.current_state), 32'(m_state));
    check("moc_wait", 32'(bus.moc_wait), 32'(m_wait));
    check("stack_err", 32'(bus.stack_err), 32'(m_err));
    check("timeout", 32'(bus.timeout), 32'(m_tmo));
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    #1;
    check("rst_state", 32'(bus.current_state), 32'd0);
    check("rst_moc_wait", 32'(bus.moc_wait), 32'd0);
    check("rst_stack_err", 32'(bus.stack_err), 32'd0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    model_reset();
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.N = '0;
    bus.cr = '0;
    bus.inv = 1'b0;
    bus.cond = 1'b0;
    bus.moc = 1'b0;
    bus.decoded_state = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Increment from reset
    step(3'd3); check("incr1", 32'(bus.current_state), 32'd1);
    step(3'd3); check("incr2", 32'(bus.current_state), 32'd2);
    step(3'd3); check("incr3", 32'(bus.current_state), 32'd3);

    // Reset mid-subroutine empties the stack
    step(3'd6, 10'd5);
    do_reset();
    step(3'd7); check("ret_empty", 32'(bus.current_state), 32'd1023);
    check("ret_empty_err", 32'(bus.stack_err), 32'd1);
    step(3'd3); step(3'd3);
    check("err_sticky", 32'(bus.stack_err), 32'd1);
    do_reset();

    // Branch and wrap
    step(3'd2, 10'd10);
    step(3'd4, 10'd200, 1'b0, 1'b1); check("branch_taken", 32'(bus.current_state), 32'd200);
    step(3'd2, 10'd10);
    step(3'd4, 10'd200, 1'b1, 1'b1); check("branch_inv", 32'(bus.current_state), 32'd11);
    step(3'd2, 10'd1023);
    step(3'd3); check("wrap", 32'(bus.current_state), 32'd0);
    step(3'd0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd777); check("decode", 32'(bus.current_state), 32'd777);
    step(3'd1); check("fetch", 32'(bus.current_state), 32'd1);

    // MOC wait
    step(3'd2, 10'd40);
    for (int i = 0; i < 3; i++) begin
      step(3'd5);
      check("moc_hold", 32'(bus.current_state), 32'd40);
      check("moc_hold_flag", 32'(bus.moc_wait), 32'd1);
    end
    step(3'd5, 10'd0, 1'b0, 1'b0, 1'b1);
    check("moc_done", 32'(bus.current_state), 32'd41);
    check("moc_done_flag", 32'(bus.moc_wait), 32'd0);

    // Reset mid-wait
    step(3'd2, 10'd40);
    step(3'd5); step(3'd5);
    do_reset();

    // Call / return
    step(3'd2, 10'd50);
    step(3'd6, 10'd300); check("call", 32'(bus.current_state), 32'd300);
    step(3'd7); check("ret", 32'(bus.current_state), 32'd51);
    step(3'd2, 10'd60);
    step(3'd6, 10'd70);
    step(3'd6, 10'd80);
    step(3'd6, 10'd90);
    step(3'd6, 10'd100); check("call4", 32'(bus.current_state), 32'd100);
    step(3'd7); check("ret91", 32'(bus.current_state), 32'd91);
    step(3'd7); check("ret81", 32'(bus.current_state), 32'd81);
    step(3'd7); check("ret71", 32'(bus.current_state), 32'd71);
    step(3'd7); check("ret61", 32'(bus.current_state), 32'd61);
    check("no_err", 32'(bus.stack_err), 32'd0);
    step(3'd2, 10'd60);
    step(3'd6, 10'd70);
    step(3'd6, 10'd80);
    step(3'd6, 10'd90);
    step(3'd6, 10'd100);
    step(3'd6, 10'd110); check("overflow", 32'(bus.current_state), 32'd1023);
    check("overflow_err", 32'(bus.stack_err), 32'd1);
    do_reset();

    // MOC watchdog
    step(3'd2, 10'd40);
`ifdef MICROSEQ_MOC_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) begin
      step(3'd5);
      check("tmo_hold", 32'(bus.current_state), 32'd40);
    end
    step(3'd5);
    check("tmo_fault", 32'(bus.current_state), 32'd1023);
    check("tmo_flag", 32'(bus.timeout), 32'd1);
`else
    for (int i = 0; i < 1000; i++) begin
      step(3'd5);
    end
    check("long_hold", 32'(bus.current_state), 32'd40);
    check("long_hold_tmo", 32'(bus.timeout), 32'd0);
`endif
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(3'($urandom_range(0, 7)), 10'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 10'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
